// File: rtl/mac_kbd_device.sv
// Mac Plus keyboard endpoint: clocks in one command byte from the VIA, answers with one response byte.
// Latency: 1 tick from the 8th command bit to the response decision; 1 tick from data-high to the first response fall.
// Backpressure: none; key codes arriving while the FIFO is full are dropped, Inquiry stalls in WAIT_KEY.
//
// Ports: clk32/_systemReset (async active-low), clk8_en_p timing enable,
//   kbd_dat_i resolved data line, kbd_clk_o/kbd_dat_o/kbd_dat_oe keyboard line drive,
//   key_strobe/key_code key events in, cmd_strobe/cmd_byte received command, busy (not IDLE).
module mac_kbd_device #(
  parameter int         HALF_CYCLE  = 1300,
  parameter int         INQ_TIMEOUT = 2000000,
  parameter logic [7:0] MODEL_ID    = 8'h0B,
  parameter int         FIFO_DEPTH  = 8
) (
  input  logic       clk32,
  input  logic       _systemReset,
  input  logic       clk8_en_p,
  input  logic       kbd_dat_i,
  output logic       kbd_clk_o,
  output logic       kbd_dat_o,
  output logic       kbd_dat_oe,
  input  logic       key_strobe,
  input  logic [7:0] key_code,
  output logic       cmd_strobe,
  output logic [7:0] cmd_byte,
  output logic       busy
);

  localparam int HALF_W = ($clog2(HALF_CYCLE) > 11) ? $clog2(HALF_CYCLE) : 11;
  localparam int TO_W   = ($clog2(INQ_TIMEOUT) > 21) ? $clog2(INQ_TIMEOUT) : 21;
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, CMD_LO, CMD_HI, WAIT_KEY, WAIT_RDY, RSP_LO, RSP_HI, RSP_END
  } stateT;

  stateT             state, stateNext;
  logic [HALF_W-1:0] halfCnt;
  logic [TO_W-1:0]   timeoutCnt;
  logic [2:0]        bitCnt;
  logic [7:0]        cmdShift;
  logic [7:0]        rspShift;
  logic              fromFifo;
  logic              lowSeen;

  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [AW:0]       wrPtr, rdPtr;
  logic              fifoEmpty, fifoFull, fifoPush, fifoPop;
  logic [7:0]        fifoHead;

  logic              halfDone, cmdEnd, timeoutHit, keyArrive;
  logic [7:0]        keyVal;
  logic [7:0]        decRsp;
  logic              decFromFifo, decWait, decFlush;

  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign fifoHead  = fifoMem[rdPtr[AW-1:0]];
  assign fifoPush  = key_strobe && !fifoFull;
  assign fifoPop   = (state == RSP_END) && fromFifo;

  assign halfDone   = clk8_en_p && (halfCnt == HALF_W'(HALF_CYCLE - 1));
  assign cmdEnd     = (state == CMD_HI) && halfDone && (bitCnt == 3'd7);
  assign timeoutHit = clk8_en_p && (timeoutCnt == TO_W'(INQ_TIMEOUT - 1));
  // A strobe this cycle is being pushed into an empty FIFO, so its code is what
  // the head will hold; a non-empty FIFO covers a key that landed during decode.
  assign keyArrive  = key_strobe || !fifoEmpty;
  assign keyVal     = fifoEmpty ? key_code : fifoHead;

  // Command decode, evaluated on the fully shifted command byte.
  always_comb begin
    decRsp      = 8'h77;
    decFromFifo = 1'b0;
    decWait     = 1'b0;
    decFlush    = 1'b0;
    case (cmdShift)
      8'h10: begin
        if (fifoEmpty) decWait = 1'b1;
        else begin decRsp = fifoHead; decFromFifo = 1'b1; end
      end
      8'h14: begin
        if (fifoEmpty) decRsp = 8'h7B;
        else begin decRsp = fifoHead; decFromFifo = 1'b1; end
      end
      8'h16: begin decRsp = MODEL_ID; decFlush = 1'b1; end
      8'h36: decRsp = 8'h7D;
      default: decRsp = 8'h77;
    endcase
  end

  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) state <= IDLE;
    else               state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (clk8_en_p && !kbd_dat_i && lowSeen) stateNext = CMD_LO;
      CMD_LO:   if (halfDone) stateNext = CMD_HI;
      CMD_HI:   if (halfDone) stateNext = (bitCnt == 3'd7) ? (decWait ? WAIT_KEY : WAIT_RDY) : CMD_LO;
      WAIT_KEY: if (keyArrive || timeoutHit) stateNext = WAIT_RDY;
      WAIT_RDY: if (clk8_en_p && kbd_dat_i) stateNext = RSP_LO;
      RSP_LO:   if (halfDone) stateNext = RSP_HI;
      RSP_HI:   if (halfDone) stateNext = (bitCnt == 3'd7) ? RSP_END : RSP_LO;
      RSP_END:  stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_comb begin
    kbd_clk_o  = !((state == CMD_LO) || (state == RSP_LO));
    kbd_dat_oe = (state == RSP_LO) || (state == RSP_HI);
    kbd_dat_o  = kbd_dat_oe ? rspShift[7] : 1'b1;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      halfCnt    <= '0;
      timeoutCnt <= '0;
      bitCnt     <= '0;
      cmdShift   <= '0;
      rspShift   <= '0;
      fromFifo   <= 1'b0;
      lowSeen    <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd_byte   <= 8'h00;
    end else begin
      cmd_strobe <= 1'b0;
      // Half-period counter restarts on every state change.
      if (state != stateNext) halfCnt <= '0;
      else if (clk8_en_p)     halfCnt <= halfCnt + 1'b1;

      if (state == IDLE) begin
        if (clk8_en_p) lowSeen <= !kbd_dat_i;
      end else begin
        lowSeen <= 1'b0;
      end

      case (state)
        IDLE:   bitCnt <= '0;
        CMD_LO: if (halfDone) cmdShift <= {cmdShift[6:0], kbd_dat_i};
        CMD_HI: begin
          if (halfDone) bitCnt <= bitCnt + 1'b1;
          if (cmdEnd) begin
            cmd_strobe <= 1'b1;
            cmd_byte   <= cmdShift;
            rspShift   <= decRsp;
            fromFifo   <= decFromFifo;
            timeoutCnt <= '0;
          end
        end
        WAIT_KEY: begin
          if (clk8_en_p) timeoutCnt <= timeoutCnt + 1'b1;
          if (keyArrive) begin
            rspShift <= keyVal;
            fromFifo <= 1'b1;
          end else if (timeoutHit) begin
            rspShift <= 8'h7B;
            fromFifo <= 1'b0;
          end
        end
        WAIT_RDY: bitCnt <= '0;
        RSP_HI: begin
          if (halfDone) begin
            bitCnt   <= bitCnt + 1'b1;
            rspShift <= {rspShift[6:0], 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (fifoPush) wrPtr <= wrPtr + 1'b1;
      // Flush only happens at command decode, never in the same cycle as a pop.
      if (cmdEnd && decFlush) rdPtr <= wrPtr;
      else if (fifoPop)       rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk32) begin
    if (fifoPush) fifoMem[wrPtr[AW-1:0]] <= key_code;
  end

endmodule

// File: tb/tb_mac_kbd_device.sv
module tb_mac_kbd_device;
  localparam int HC = 4;
  localparam int TO = 1000;
  localparam int DEPTH = 8;
  localparam logic [7:0] MID = 8'h0B;

  logic clk32 = 1'b0;
  logic _systemReset = 1'b0;
  logic clk8_en_p = 1'b0;
  logic macDat = 1'b1;
  logic key_strobe = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic kbd_dat_i;
  logic kbd_clk_o, kbd_dat_o, kbd_dat_oe, cmd_strobe, busy;
  logic [7:0] cmd_byte;

  int checks = 0;
  int failures = 0;
  int strobeCount = 0;
  logic [7:0] modelQ [$];

  // Open-drain line: either side can pull it low.
  assign kbd_dat_i = macDat & (kbd_dat_oe ? kbd_dat_o : 1'b1);

  mac_kbd_device #(.HALF_CYCLE(HC), .INQ_TIMEOUT(TO), .MODEL_ID(MID), .FIFO_DEPTH(DEPTH)) dut (
    .clk32(clk32), ._systemReset(_systemReset), .clk8_en_p(clk8_en_p),
    .kbd_dat_i(kbd_dat_i), .kbd_clk_o(kbd_clk_o), .kbd_dat_o(kbd_dat_o), .kbd_dat_oe(kbd_dat_oe),
    .key_strobe(key_strobe), .key_code(key_code), .cmd_strobe(cmd_strobe), .cmd_byte(cmd_byte),
    .busy(busy)
  );

  initial forever #5 clk32 = ~clk32;
  initial forever begin @(posedge clk32); #1 clk8_en_p = ~clk8_en_p; end
  always @(posedge clk32) if (cmd_strobe === 1'b1) strobeCount <= strobeCount + 1;

  task automatic waitEdge(input bit rising, input int budget, output bit ok, output int cycles);
    logic prev;
    prev = kbd_clk_o; ok = 0; cycles = 0;
    while (!ok && cycles < budget) begin
      @(posedge clk32); #1; cycles++;
      if (rising ? (!prev && kbd_clk_o) : (prev && !kbd_clk_o)) ok = 1;
      prev = kbd_clk_o;
    end
  endtask

  task automatic sendCmd(input logic [7:0] cmd, output bit ok);
    bit e; int c;
    ok = 1;
    macDat = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      waitEdge(0, 400, e, c); if (!e) ok = 0;
      macDat = cmd[i];
      waitEdge(1, 400, e, c); if (!e) ok = 0;
    end
    macDat = 1'b1;
  endtask

  task automatic recvRsp(output logic [7:0] rsp, output bit ok, output int latency);
    bit e; int c;
    rsp = 8'h00;
    waitEdge(0, 5000, e, latency); ok = e;
    for (int i = 7; i >= 0; i--) begin
      waitEdge(1, 400, e, c); if (!e) ok = 0;
      rsp[i] = kbd_dat_i;
    end
    c = 0;
    while (busy && c < 400) begin @(posedge clk32); #1; c++; end
    if (busy) ok = 0;
  endtask

  task automatic pushKey(input logic [7:0] code);
    key_code = code; key_strobe = 1'b1;
    @(posedge clk32); #1;
    key_strobe = 1'b0;
    if (modelQ.size() < DEPTH) modelQ.push_back(code);
  endtask

  // Reference behaviour of one complete command/response exchange with no keys arriving.
  task automatic modelCmd(input logic [7:0] cmd, output logic [7:0] rsp);
    case (cmd)
      8'h10, 8'h14: rsp = (modelQ.size() > 0) ? modelQ.pop_front() : 8'h7B;
      8'h16: begin modelQ.delete(); rsp = MID; end
      8'h36: rsp = 8'h7D;
      default: rsp = 8'h77;
    endcase
  endtask

  task automatic transact(input logic [7:0] cmd, input string name);
    bit ok1, ok2; int lat; logic [7:0] rsp, exp;
    modelCmd(cmd, exp);
    sendCmd(cmd, ok1);
    recvRsp(rsp, ok2, lat);
    checks++;
    if (!(ok1 && ok2) || rsp !== exp) begin
      failures++;
      $display("FAIL %s cmd=%02h rsp=%02h expected=%02h handshake_ok=%0d", name, cmd, rsp, exp, ok1 && ok2);
    end
  endtask

  task automatic test_reset();
    _systemReset = 1'b0;
    repeat (3) @(posedge clk32); #1;
    checks++;
    if ({kbd_clk_o, kbd_dat_o, kbd_dat_oe, cmd_strobe, busy} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_lines clk/dat/oe/strobe/busy=%b expected=11000",
               {kbd_clk_o, kbd_dat_o, kbd_dat_oe, cmd_strobe, busy});
    end
    checks++;
    if (cmd_byte !== 8'h00) begin failures++; $display("FAIL reset_cmd_byte got=%02h expected=00", cmd_byte); end
    _systemReset = 1'b1;
    repeat (4) @(posedge clk32); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b expected=0", busy); end
    modelQ.delete();
  endtask

  task automatic test_test_cmd();
    int s0;
    s0 = strobeCount;
    transact(8'h36, "test_cmd_rsp");
    checks++;
    if (cmd_byte !== 8'h36) begin failures++; $display("FAIL test_cmd_byte got=%02h expected=36", cmd_byte); end
    checks++;
    if (strobeCount - s0 !== 1) begin failures++; $display("FAIL test_cmd_strobes got=%0d expected=1", strobeCount - s0); end
    checks++;
    if (kbd_dat_oe !== 1'b0 || kbd_clk_o !== 1'b1) begin
      failures++; $display("FAIL test_cmd_release oe=%b clk=%b expected oe=0 clk=1", kbd_dat_oe, kbd_clk_o);
    end
  endtask

  task automatic test_instant();
    transact(8'h14, "instant_empty");
    pushKey(8'h0F);
    transact(8'h14, "instant_key");
    transact(8'h14, "instant_after_pop");
  endtask

  task automatic test_inquiry();
    bit ok1, ok2; int lat; logic [7:0] rsp;
    sendCmd(8'h10, ok1);
    recvRsp(rsp, ok2, lat);
    checks++;
    if (!(ok1 && ok2) || rsp !== 8'h7B) begin
      failures++; $display("FAIL inquiry_timeout_rsp got=%02h expected=7B ok=%0d", rsp, ok1 && ok2);
    end
    // 1000 timeout ticks plus the final high phase and the ready tick, two clk32 cycles per tick.
    checks++;
    if (lat < 2 * TO - 10 || lat > 2 * TO + 40) begin
      failures++; $display("FAIL inquiry_timeout_latency got=%0d cycles expected=%0d..%0d", lat, 2 * TO - 10, 2 * TO + 40);
    end
    sendCmd(8'h10, ok1);
    repeat (1000) @(posedge clk32); #1;
    pushKey(8'h0F);
    recvRsp(rsp, ok2, lat);
    void'(modelQ.pop_front());
    checks++;
    if (!(ok1 && ok2) || rsp !== 8'h0F) begin
      failures++; $display("FAIL inquiry_key_rsp got=%02h expected=0F ok=%0d", rsp, ok1 && ok2);
    end
    checks++;
    if (lat > 20) begin failures++; $display("FAIL inquiry_key_latency got=%0d cycles expected<=20", lat); end
    transact(8'h14, "inquiry_key_popped");
    pushKey(8'($urandom_range(1, 255)));
    transact(8'h10, "inquiry_nonempty");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 10; i++) pushKey(8'(i));
    for (int i = 0; i < 9; i++) transact(8'h14, "overflow_instant");
  endtask

  task automatic test_model();
    for (int i = 0; i < 3; i++) pushKey(8'($urandom_range(0, 255)));
    transact(8'h16, "model_rsp");
    transact(8'h14, "model_flushed");
    transact(8'h55, "unknown_cmd");
  endtask

  task automatic test_random();
    logic [7:0] cmds [5];
    cmds[0] = 8'h10; cmds[1] = 8'h14; cmds[2] = 8'h16; cmds[3] = 8'h36;
    for (int n = 0; n < 8; n++) begin
      int k;
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) pushKey(8'($urandom_range(0, 255)));
      cmds[4] = 8'($urandom_range(0, 255));
      transact(cmds[$urandom_range(0, 4)], "random_cmd");
    end
  endtask

  task automatic test_reset_mid();
    bit ok1, e; int c;
    sendCmd(8'h36, ok1);
    waitEdge(0, 400, e, c);
    for (int i = 0; i < 3; i++) waitEdge(1, 400, e, c);
    #2 _systemReset = 1'b0;
    #1;
    checks++;
    if (kbd_clk_o !== 1'b1 || kbd_dat_oe !== 1'b0 || kbd_dat_o !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid clk=%b oe=%b dat=%b busy=%b expected clk=1 oe=0 dat=1 busy=0",
               kbd_clk_o, kbd_dat_oe, kbd_dat_o, busy);
    end
    modelQ.delete();
    @(posedge clk32); #1 _systemReset = 1'b1;
    repeat (4) @(posedge clk32); #1;
    transact(8'h36, "after_reset_test");
  endtask

  initial begin
    test_reset();
    test_test_cmd();
    test_instant();
    test_inquiry();
    test_overflow();
    test_model();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
